// File: rtl/dmem_order_checker.sv
// Data-memory self-check engine: streams N consecutive words through a read
// port and reports whether they are ordered, plus the violation count and first offending pair.
module dmem_order_checker #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              cfg_signed,
  input  logic              cfg_desc,
  input  logic              cfg_strict,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [DATA_W-1:0] first_err_prev,
  output logic [DATA_W-1:0] first_err_curr
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("dmem_order_checker: RD_LAT must be in 1..4");
  end

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_FINISH} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              sgn_q, desc_q, strict_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [ADDR_W-1:0] last_idx;
  logic [DATA_W-1:0] prev_q;

  logic [RD_LAT-1:0] pipe_vld_q;
  logic [ADDR_W-1:0] pipe_idx_q [RD_LAT];

  logic              accept, in_run, abort_run, issue_last;
  logic              ret_vld, ret_last, cmp_en, viol;
  logic [ADDR_W-1:0] ret_idx;

  logic              rd_en_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d, rd_idx_d;

  logic signed [DATA_W:0] cur_x, prv_x;
  logic                   lt, gt, eq;

  // Index arithmetic stays in ADDR_W bits: a full-memory count maps to last_idx = all-ones.
  assign in_run     = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign accept     = (state_q == S_IDLE) && start && !abort;
  assign abort_run  = in_run && abort;
  assign last_idx   = ADDR_W'(cnt_q - CNT_W'(1));
  assign issue_last = (state_q == S_SCAN) && (rd_idx_q == last_idx);
  assign ret_vld    = pipe_vld_q[RD_LAT-1] && !abort_run;
  assign ret_idx    = pipe_idx_q[RD_LAT-1];
  assign ret_last   = ret_vld && (ret_idx == last_idx);
  assign cmp_en     = ret_vld && (ret_idx != '0);

  // Ordering test on one extra bit so signed and unsigned share one comparator.
  always_comb begin
    cur_x = {sgn_q & mem_rdata[DATA_W-1], mem_rdata};
    prv_x = {sgn_q & prev_q[DATA_W-1], prev_q};
    lt    = cur_x < prv_x;
    gt    = cur_x > prv_x;
    eq    = (mem_rdata == prev_q);
    viol  = desc_q ? (gt || (strict_q && eq)) : (lt || (strict_q && eq));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = (count >= CNT_W'(2)) ? S_SCAN : S_FINISH;
      end
      S_SCAN: begin
        if (abort)           state_d = S_IDLE;
        else if (issue_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)         state_d = S_IDLE;
        else if (ret_last) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered control outputs
  always_comb begin
    rd_en_d  = (state_d == S_SCAN);
    busy_d   = (state_d == S_SCAN) || (state_d == S_DRAIN);
    done_d   = (state_d == S_FINISH);
    addr_d   = mem_addr;
    rd_idx_d = rd_idx_q;
    if (accept) begin
      addr_d   = base_addr;
      rd_idx_d = '0;
    end else if ((state_q == S_SCAN) && (state_d == S_SCAN)) begin
      addr_d   = mem_addr + ADDR_W'(1);
      rd_idx_d = rd_idx_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      rd_idx_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd_en <= rd_en_d;
      mem_addr  <= addr_d;
      rd_idx_q  <= rd_idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Scan parameters are frozen at start so input changes mid-scan are harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      desc_q   <= 1'b0;
      strict_q <= 1'b0;
    end else if (accept) begin
      cnt_q    <= count;
      sgn_q    <= cfg_signed;
      desc_q   <= cfg_desc;
      strict_q <= cfg_strict;
    end
  end

  // Return tags: each strobe's index travels alongside its read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_q <= '0;
      for (int unsigned j = 0; j < RD_LAT; j++) pipe_idx_q[j] <= '0;
    end else begin
      pipe_vld_q[0] <= mem_rd_en && !abort_run;
      pipe_idx_q[0] <= rd_idx_q;
      for (int unsigned j = 1; j < RD_LAT; j++) begin
        pipe_vld_q[j] <= pipe_vld_q[j-1] && !abort_run;
        pipe_idx_q[j] <= pipe_idx_q[j-1];
      end
    end
  end

  // Result accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass           <= 1'b1;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_prev <= '0;
      first_err_curr <= '0;
      prev_q         <= '0;
    end else if (accept) begin
      pass           <= 1'b1;
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_prev <= '0;
      first_err_curr <= '0;
    end else if (ret_vld) begin
      prev_q <= mem_rdata;
      if (cmp_en && viol) begin
        pass <= 1'b0;
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (err_count == '0) begin
          first_err_idx  <= ret_idx;
          first_err_prev <= prev_q;
          first_err_curr <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_order_checker.sv
// Bench for dmem_order_checker: two instances (read latency 1 and 3) share stimulus;
// results are compared against a list-level ordering model over the bench's memory image.
module tb_dmem_order_checker;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MAXLOG = DEPTH + 16;
  localparam int SAT    = (1 << CNT_W) - 1;
  localparam logic [DATA_W-1:0] IDLE_DATA = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset;
  logic start, abort, cfg_signed, cfg_desc, cfg_strict;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;

  logic [1:0]             rd_en_w, busy_w, done_w, pass_w;
  logic [1:0][ADDR_W-1:0] addr_w, idx_w;
  logic [1:0][ADDR_W:0]   err_w;
  logic [1:0][DATA_W-1:0] rdata_w, prev_w, curr_w;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] l3_a, l3_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc = 0;
  int done_cnt [2];
  int done_at  [2];
  int busy_cnt [2];
  int rd_cnt   [2];
  int addr_log [2][MAXLOG];

  always #5 clk = ~clk;

  dmem_order_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count),
    .cfg_signed(cfg_signed), .cfg_desc(cfg_desc), .cfg_strict(cfg_strict),
    .mem_rd_en(rd_en_w[0]), .mem_addr(addr_w[0]), .mem_rdata(rdata_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_count(err_w[0]),
    .first_err_idx(idx_w[0]), .first_err_prev(prev_w[0]), .first_err_curr(curr_w[0])
  );

  dmem_order_checker #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count),
    .cfg_signed(cfg_signed), .cfg_desc(cfg_desc), .cfg_strict(cfg_strict),
    .mem_rd_en(rd_en_w[1]), .mem_addr(addr_w[1]), .mem_rdata(rdata_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_count(err_w[1]),
    .first_err_idx(idx_w[1]), .first_err_prev(prev_w[1]), .first_err_curr(curr_w[1])
  );

  // Memory models; data outside a strobe's return slot is poisoned.
  always @(posedge clk) begin
    rdata_w[0] <= rd_en_w[0] ? mem[addr_w[0]] : IDLE_DATA;
    l3_a       <= rd_en_w[1] ? mem[addr_w[1]] : IDLE_DATA;
    l3_b       <= l3_a;
    rdata_w[1] <= l3_b;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Activity monitor; cycle numbers are relative to the start edge (cycle 1 follows it).
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_w[i]) begin
        done_cnt[i]++;
        done_at[i] = cyc - start_cyc + 1;
      end
      if (busy_w[i]) busy_cnt[i]++;
      if (rd_en_w[i]) begin
        if (rd_cnt[i] < MAXLOG) addr_log[i][rd_cnt[i]] = int'(addr_w[i]);
        rd_cnt[i]++;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic string tg(input int i, input string s);
    return $sformatf("L%0d_%s", (i == 0) ? 1 : 3, s);
  endfunction

  // Reference: walk the list of n elements from base and apply the ordering rules.
  task automatic ref_model(input int base, input int n, input bit sgn, input bit desc,
                           input bit strict, output bit exp_pass, output int errs,
                           output int fidx, output logic [DATA_W-1:0] fprev,
                           output logic [DATA_W-1:0] fcurr);
    logic [DATA_W-1:0] p, c;
    longint a, b;
    bit bad;
    exp_pass = 1'b1; errs = 0; fidx = 0; fprev = '0; fcurr = '0;
    for (int k = 1; k < n; k++) begin
      p = mem[(base + k - 1) % DEPTH];
      c = mem[(base + k) % DEPTH];
      a = sgn ? longint'(signed'(p)) : longint'(p);
      b = sgn ? longint'(signed'(c)) : longint'(c);
      bad = desc ? (b > a) : (b < a);
      if (strict && (a == b)) bad = 1'b1;
      if (bad) begin
        if (errs == 0) begin
          fidx = k; fprev = p; fcurr = c;
        end
        errs++;
        exp_pass = 1'b0;
      end
    end
    if (errs > SAT) errs = SAT;
  endtask

  task automatic load(input int base, input logic [DATA_W-1:0] vals[$]);
    foreach (vals[k]) mem[(base + k) % DEPTH] = vals[k];
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq(tg(i, {tag, "_done"}),  64'(done_w[i]),  64'(0));
      check_eq(tg(i, {tag, "_busy"}),  64'(busy_w[i]),  64'(0));
      check_eq(tg(i, {tag, "_rd_en"}), 64'(rd_en_w[i]), 64'(0));
      check_eq(tg(i, {tag, "_addr"}),  64'(addr_w[i]),  64'(0));
      check_eq(tg(i, {tag, "_pass"}),  64'(pass_w[i]),  64'(1));
      check_eq(tg(i, {tag, "_err"}),   64'(err_w[i]),   64'(0));
      check_eq(tg(i, {tag, "_idx"}),   64'(idx_w[i]),   64'(0));
      check_eq(tg(i, {tag, "_prev"}),  64'(prev_w[i]),  64'(0));
      check_eq(tg(i, {tag, "_curr"}),  64'(curr_w[i]),  64'(0));
    end
  endtask

  // Pulse start (optionally held for extra cycles), then scramble the inputs mid-scan.
  task automatic launch(input int base, input int n, input bit sgn, input bit desc,
                        input bit strict, input int hold);
    @(negedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; done_at[i] = 0; busy_cnt[i] = 0; rd_cnt[i] = 0;
    end
    base_addr  = ADDR_W'(base);
    count      = CNT_W'(n);
    cfg_signed = sgn;
    cfg_desc   = desc;
    cfg_strict = strict;
    start      = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = ADDR_W'($urandom);
    count      = CNT_W'($urandom);
    cfg_signed = 1'($urandom_range(0, 1));
    cfg_desc   = 1'($urandom_range(0, 1));
    cfg_strict = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_and_check(input int base, input int n, input bit sgn, input bit desc,
                                input bit strict);
    int budget, lat, fidx, errs;
    bit ep;
    logic [DATA_W-1:0] fp, fc;
    budget = n + 16;
    while (budget > 0 && !(done_cnt[0] > 0 && done_cnt[1] > 0)) begin
      @(posedge clk);
      budget--;
    end
    repeat (4) @(posedge clk);
    #1;
    ref_model(base, n, sgn, desc, strict, ep, errs, fidx, fp, fc);
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      check_eq(tg(i, "done_cnt"), 64'(done_cnt[i]), 64'(1));
      check_eq(tg(i, "done_cycle"), 64'(done_at[i]), 64'((n >= 2) ? n + lat + 1 : 1));
      check_eq(tg(i, "busy_cycles"), 64'(busy_cnt[i]), 64'((n >= 2) ? n + lat : 0));
      check_eq(tg(i, "reads"), 64'(rd_cnt[i]), 64'((n >= 2) ? n : 0));
      check_eq(tg(i, "pass"), 64'(pass_w[i]), 64'(ep));
      check_eq(tg(i, "err_count"), 64'(err_w[i]), 64'(errs));
      check_eq(tg(i, "first_idx"), 64'(idx_w[i]), 64'(fidx));
      check_eq(tg(i, "first_prev"), 64'(prev_w[i]), 64'(fp));
      check_eq(tg(i, "first_curr"), 64'(curr_w[i]), 64'(fc));
      for (int k = 0; k < n && k < rd_cnt[i] && k < MAXLOG; k++)
        check_eq(tg(i, $sformatf("addr%0d", k)), 64'(addr_log[i][k]), 64'((base + k) % DEPTH));
    end
  endtask

  task automatic run(input int base, input int n, input bit sgn, input bit desc,
                     input bit strict, input int hold);
    launch(base, n, sgn, desc, strict, hold);
    wait_and_check(base, n, sgn, desc, strict);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] v;
    v = DATA_W'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) v = v - DATA_W'(4);
    return v;
  endfunction

  initial begin
    logic [DATA_W-1:0] q[$];
    int ip, ie, ix, m, lat;
    bit bp;
    logic [DATA_W-1:0] xp, xc;

    reset = 1'b0; start = 1'b0; abort = 1'b0;
    base_addr = '0; count = '0;
    cfg_signed = 1'b0; cfg_desc = 1'b0; cfg_strict = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    repeat (3) @(posedge clk); #1;
    check_reset_vals("por");
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_reset_vals("idle");

    // Sorted 1..10 from address 0
    q = '{};
    for (int k = 1; k <= 10; k++) q.push_back(DATA_W'(k));
    load(0, q);
    run(0, 10, 1'b0, 1'b0, 1'b0, 0);

    // Unsorted list, non-strict then strict
    q = '{32'd5, 32'd3, 32'd8, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd6, 32'd4};
    load(100, q);
    run(100, 10, 1'b0, 1'b0, 1'b0, 0);
    run(100, 10, 1'b0, 1'b0, 1'b1, 0);

    // Signed vs unsigned interpretation
    q = '{32'hFFFF_FFFF, 32'd0, 32'd1};
    load(40, q);
    run(40, 3, 1'b1, 1'b0, 1'b0, 0);
    run(40, 3, 1'b0, 1'b0, 1'b0, 0);

    // Descending across the top of memory
    q = '{32'd9, 32'd7, 32'd7, 32'd2};
    load(DEPTH - 2, q);
    run(DEPTH - 2, 4, 1'b0, 1'b1, 1'b0, 0);
    run(DEPTH - 2, 4, 1'b0, 1'b1, 1'b1, 0);

    // Degenerate lengths
    run(7, 0, 1'b0, 1'b0, 1'b0, 0);
    run(7, 1, 1'b0, 1'b0, 1'b1, 0);

    // start held high for several scan cycles
    run(0, 10, 1'b0, 1'b0, 1'b0, 5);

    // Abort during cycle 4 of an unsorted scan
    q = '{32'd5, 32'd3, 32'd8, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd6, 32'd4};
    load(100, q);
    launch(100, 10, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq(tg(i, "abort_busy"), 64'(busy_w[i]), 64'(0));
      check_eq(tg(i, "abort_rd_en"), 64'(rd_en_w[i]), 64'(0));
    end
    repeat (20) @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      m = (3 - lat > 0) ? 3 - lat : 0;
      ref_model(100, m, 1'b0, 1'b0, 1'b0, bp, ie, ix, xp, xc);
      check_eq(tg(i, "abort_done"), 64'(done_cnt[i]), 64'(0));
      check_eq(tg(i, "abort_reads"), 64'(rd_cnt[i]), 64'(4));
      check_eq(tg(i, "abort_pass"), 64'(pass_w[i]), 64'(bp));
      check_eq(tg(i, "abort_err"), 64'(err_w[i]), 64'(ie));
    end
    q = '{};
    for (int k = 1; k <= 10; k++) q.push_back(DATA_W'(k * 3));
    load(100, q);
    run(100, 10, 1'b0, 1'b0, 1'b1, 0);

    // Reset asserted mid-scan
    q = '{32'd5, 32'd3, 32'd8, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd6, 32'd4};
    load(200, q);
    launch(200, 10, 1'b0, 1'b0, 1'b0, 0);
    repeat (5) @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 3;
      ref_model(200, 5 - lat, 1'b0, 1'b0, 1'b0, bp, ie, ix, xp, xc);
      check_eq(tg(i, "pre_rst_err"), 64'(err_w[i]), 64'(ie));
    end
    #1 reset = 1'b0;
    #1 check_reset_vals("mid_rst");
    @(negedge clk); reset = 1'b1;
    repeat (20) @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      check_eq(tg(i, "rst_no_done"), 64'(done_cnt[i]), 64'(0));

    // Whole memory, ascending ramp starting at 5: one wrap violation
    for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(a);
    run(5, DEPTH, 1'b0, 1'b0, 1'b0, 0);

    // Randomised scans
    for (int r = 0; r < 30; r++) begin
      int base, n, hold;
      bit s, d, st;
      logic [DATA_W-1:0] v;
      base = int'($urandom_range(0, DEPTH - 1));
      n    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 24));
      s    = 1'($urandom_range(0, 1));
      d    = 1'($urandom_range(0, 1));
      st   = 1'($urandom_range(0, 1));
      hold = (n >= 2) ? int'($urandom_range(0, 2)) : 0;
      v    = rand_word();
      for (int k = 0; k < n; k++) begin
        if (r % 2 == 0) v = rand_word();
        else v = d ? v - DATA_W'($urandom_range(0, 2)) : v + DATA_W'($urandom_range(0, 2));
        mem[(base + k) % DEPTH] = v;
      end
      run(base, n, s, d, st, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
